// File: rtl/divider_sched_pkg.sv
// Shared types and constants for the divider scheduler.
package divider_sched_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Index of the set bit in a one-hot vector of up to 8 bits.
  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    onehot_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) onehot_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/divider_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LW-1:0]      last,
  output logic [NUM_REQ-1:0] grant_c,
  output logic               valid_c
);

  logic [LW-1:0] idx;

  always_comb begin
    grant_c = '0;
    valid_c = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = LW'((32'(last) + k) % NUM_REQ);
      if (!valid_c && req[idx]) begin
        grant_c[idx] = 1'b1;
        valid_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divider_scheduler.sv
// Round-robin scheduler sharing one divider among NUM_REQ requesters.
// Optional RUN-state abort counter enabled by DIV_SCHED_TIMEOUT_EN.
module divider_scheduler
  import divider_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic [WIDTH-1:0]         rsp_remainder,
  output logic                     rsp_error,
  output logic                     busy,
  output logic                     div_go,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  output logic [3:0]               div_n,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  input  logic                     div_error,
  input  logic                     div_done
);

  localparam int unsigned LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state;
  logic [LW-1:0]      last;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] grant_c;
  logic               grant_vld_c;
  logic [LW-1:0]      grant_idx_c;
  logic [WIDTH-1:0]   sel_dividend_c;
  logic [WIDTH-1:0]   sel_divisor_c;

`ifdef DIV_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  assign div_n = 4'(WIDTH);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LW      (LW)
  ) u_arb (
    .req     (req),
    .last    (last),
    .grant_c (grant_c),
    .valid_c (grant_vld_c)
  );

  // Operand slice and index of the winning requester.
  always_comb begin
    sel_dividend_c = '0;
    sel_divisor_c  = '0;
    grant_idx_c    = LW'(onehot_idx(8'(grant_c)));
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        sel_dividend_c = req_dividend[i*WIDTH +: WIDTH];
        sel_divisor_c  = req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      last          <= LW'(NUM_REQ - 1);
      gnt_q         <= '0;
      ack           <= '0;
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_error     <= 1'b0;
      busy          <= 1'b0;
      div_go        <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
`ifdef DIV_SCHED_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      ack       <= '0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_vld_c) begin
            ack          <= grant_c;
            gnt_q        <= grant_c;
            last         <= grant_idx_c;
            div_dividend <= sel_dividend_c;
            div_divisor  <= sel_divisor_c;
            busy         <= 1'b1;
            if (sel_divisor_c != '0) begin
              state  <= ST_RUN;
              div_go <= 1'b1;
`ifdef DIV_SCHED_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              // Divide-by-zero answered locally; the divider is never started.
              state         <= ST_RESP;
              rsp_valid     <= grant_c;
              rsp_error     <= 1'b1;
              rsp_quotient  <= '0;
              rsp_remainder <= '0;
            end
          end
        end
        ST_RUN: begin
`ifdef DIV_SCHED_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + TW'(1);
`endif
          if (div_done) begin
            state         <= ST_RESP;
            div_go        <= 1'b0;
            rsp_valid     <= gnt_q;
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_error     <= div_error;
          end
`ifdef DIV_SCHED_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state         <= ST_RESP;
            div_go        <= 1'b0;
            rsp_valid     <= gnt_q;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_error     <= 1'b1;
          end
`endif
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          div_go <= 1'b0;
        end
      endcase
    end
  end

endmodule
